quiescence_sequencer: RTL and testbench



---
 rtl/quiescence_sequencer_pkg.sv | 28 ++
 rtl/quiescence_sequencer_find_first.sv | 23 ++
 rtl/quiescence_sequencer.sv | 169 ++++++++++++++++
 tb/tb_quiescence_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quiescence_sequencer_pkg.sv
// Shared types for the quiescence sequencer: per-slot request/response
// records, default sizing and the sweep state encoding.
package quiescence_sequencer_pkg;

  localparam int QSEQ_NUM_SLOTS       = 8;
  localparam int QSEQ_TIMEOUT_DEFAULT = 1024;
  localparam int QSEQ_TIMER_W         = 16;

  typedef struct packed {
    logic        valid;
    logic        isRequest;
    logic [63:0] data;
  } QuiescenceReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } QuiescenceResp;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    POLL,
    NEXT,
    DONE
  } QSeqState;

endpackage

// File: rtl/quiescence_sequencer_find_first.sv
// Combinational lowest-set-bit encoder used to pick the next slot to sweep.
module qseq_find_first #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quiescence_sequencer.sv
// Sweeps the selected app slots in ascending order: one quiesce request per
// slot, then polls its check until quiesced or the per-slot timeout expires.
module quiescence_sequencer
  import quiescence_sequencer_pkg::*;
#(
  parameter int NUM_SLOTS      = QSEQ_NUM_SLOTS,
  parameter int TIMEOUT_CYCLES = QSEQ_TIMEOUT_DEFAULT,
  parameter int TIMER_W        = QSEQ_TIMER_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  input  logic [NUM_SLOTS-1:0]    cmd_mask,
  output logic                    cmd_ready,
  output logic [NUM_SLOTS-1:0]    slot_qreq_valid,
  output logic [NUM_SLOTS-1:0]    slot_qreq_isRequest,
  output logic [64*NUM_SLOTS-1:0] slot_qreq_data,
  input  logic [NUM_SLOTS-1:0]    slot_qresp_valid,
  input  logic [64*NUM_SLOTS-1:0] slot_qresp_data,
  output logic                    busy,
  output logic                    done_valid,
  output logic [NUM_SLOTS-1:0]    done_quiesced,
  output logic [NUM_SLOTS-1:0]    done_timedout,
  output logic [31:0]             done_cycles
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  // Command handshake: a sweep is accepted on a cycle with cmd_valid && cmd_ready;
  // cmd_ready is only high in IDLE, so the requester holds cmd_valid until then.
  QSeqState               state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_SLOTS-1:0]   pending_q, pending_d;
  logic [NUM_SLOTS-1:0]   quies_q, quies_d;
  logic [NUM_SLOTS-1:0]   tmo_q, tmo_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]   done_q_q, done_t_q;
  logic [31:0]            done_c_q;

  logic [NUM_SLOTS-1:0]   cur_bit;
  logic [NUM_SLOTS-1:0]   ff_vec;
  logic [IDX_W-1:0]       ff_idx;
  logic                   ff_any;
  logic [NUM_SLOTS-1:0]   resp_ok;
  logic                   unused_resp_bits;

  assign cur_bit = NUM_SLOTS'(1) << idx_q;
  // In IDLE the encoder looks at the incoming mask, in NEXT at what remains.
  assign ff_vec  = (state_q == IDLE) ? cmd_mask : (pending_q & ~cur_bit);

  qseq_find_first #(.N(NUM_SLOTS), .IDX_W(IDX_W)) u_find_first (
    .vec_i (ff_vec),
    .idx_o (ff_idx),
    .any_o (ff_any)
  );

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_resp
    assign resp_ok[g] = slot_qresp_valid[g] & slot_qresp_data[64*g];
  end
  assign unused_resp_bits = ^slot_qresp_data;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    quies_d   = quies_q;
    tmo_d     = tmo_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    if ((state_q inside {ISSUE, POLL, NEXT}) && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pending_d = cmd_mask;
          quies_d   = '0;
          tmo_d     = '0;
          cnt_d     = '0;
          timer_d   = '0;
          idx_d     = ff_idx;
          state_d   = ff_any ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = POLL;
      end
      POLL: begin
        // A quiesced answer wins over the timeout on the final poll cycle.
        if (resp_ok[idx_q]) begin
          quies_d = quies_q | cur_bit;
          state_d = NEXT;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = tmo_q | cur_bit;
          state_d = NEXT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      NEXT: begin
        pending_d = pending_q & ~cur_bit;
        if (ff_any) begin
          idx_d   = ff_idx;
          state_d = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      quies_q   <= '0;
      tmo_q     <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      done_q_q  <= '0;
      done_t_q  <= '0;
      done_c_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      quies_q   <= quies_d;
      tmo_q     <= tmo_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      // The summary becomes visible in the DONE cycle and then holds.
      if (state_d == DONE) begin
        done_q_q <= quies_d;
        done_t_q <= tmo_d;
        done_c_q <= cnt_d;
      end
    end
  end

  always_comb begin
    slot_qreq_valid     = '0;
    slot_qreq_isRequest = '0;
    slot_qreq_data      = '0;
    if (state_q == ISSUE || state_q == POLL) begin
      slot_qreq_valid = cur_bit;
    end
    if (state_q == ISSUE) begin
      slot_qreq_isRequest = cur_bit;
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_qreq_valid[i]) begin
        slot_qreq_data[64*i +: 64] = 64'h1;
      end
    end
  end

  assign cmd_ready     = rst_n && (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done_valid    = (state_q == DONE);
  assign done_quiesced = done_q_q;
  assign done_timedout = done_t_q;
  assign done_cycles   = done_c_q;

endmodule

// File: tb/tb_quiescence_sequencer.sv
// Randomized bench for quiescence_sequencer: an expected per-cycle trace is
// built from each accepted mask and the slots' scheduled answer times.
module tb_quiescence_sequencer;

  localparam int NS = 8;
  localparam int T  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [NS-1:0]   cmd_mask = '0;
  logic            cmd_ready;
  logic [NS-1:0]   slot_qreq_valid;
  logic [NS-1:0]   slot_qreq_isRequest;
  logic [64*NS-1:0] slot_qreq_data;
  logic [NS-1:0]   resp_v = '0;
  logic [64*NS-1:0] resp_d = '0;
  logic            busy;
  logic            done_valid;
  logic [NS-1:0]   done_quiesced;
  logic [NS-1:0]   done_timedout;
  logic [31:0]     done_cycles;

  quiescence_sequencer #(.NUM_SLOTS(NS), .TIMEOUT_CYCLES(T), .TIMER_W(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_mask            (cmd_mask),
    .cmd_ready           (cmd_ready),
    .slot_qreq_valid     (slot_qreq_valid),
    .slot_qreq_isRequest (slot_qreq_isRequest),
    .slot_qreq_data      (slot_qreq_data),
    .slot_qresp_valid    (resp_v),
    .slot_qresp_data     (resp_d),
    .busy                (busy),
    .done_valid          (done_valid),
    .done_quiesced       (done_quiesced),
    .done_timedout       (done_timedout),
    .done_cycles         (done_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  // Poll cycle (1-based) on which each slot answers quiesced; 0 or >T = never.
  int hit_at[NS];
  int poll_cnt[NS];

  typedef struct packed {
    logic [NS-1:0] v;
    logic [NS-1:0] r;
    logic          busy;
    logic          dv;
    logic [NS-1:0] q;
    logic [NS-1:0] t;
    logic [31:0]   c;
  } exp_t;
  exp_t exp_q[$];

  logic          prev_idle = 1'b1;
  logic [NS-1:0] m_q = '0, m_t = '0;
  logic [31:0]   m_c = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Sweep as a flat list of cycles: request, polls, gap per slot, then summary.
  task automatic build_trace(input logic [NS-1:0] m);
    exp_t e;
    int c, n;
    logic hit;
    logic [NS-1:0] q, t;
    c = 0; q = '0; t = '0;
    for (int i = 0; i < NS; i++) begin
      if (m[i]) begin
        e = '0; e.busy = 1'b1; e.v = NS'(1 << i); e.r = e.v;
        exp_q.push_back(e); c++;
        hit = (hit_at[i] >= 1) && (hit_at[i] <= T);
        n = hit ? hit_at[i] : T;
        e.r = '0;
        repeat (n) exp_q.push_back(e);
        c += n;
        if (hit) q[i] = 1'b1; else t[i] = 1'b1;
        e = '0; e.busy = 1'b1;
        exp_q.push_back(e); c++;
      end
    end
    e = '0; e.busy = 1'b1; e.dv = 1'b1; e.q = q; e.t = t; e.c = 32'(c);
    exp_q.push_back(e);
  endtask

  // Scoreboard: checks every cycle, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc_n++;
    if (!rst_n) begin
      exp_q.delete();
      prev_idle = 1'b1;
      m_q = '0; m_t = '0; m_c = '0;
      chk("rst_valid", 64'(slot_qreq_valid), 64'h0);
      chk("rst_isreq", 64'(slot_qreq_isRequest), 64'h0);
      chk("rst_data", {63'b0, |slot_qreq_data}, 64'h0);
      chk("rst_ready", 64'(cmd_ready), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done_valid", 64'(done_valid), 64'h0);
      chk("rst_done_q", 64'(done_quiesced), 64'h0);
      chk("rst_done_t", 64'(done_timedout), 64'h0);
      chk("rst_done_c", 64'(done_cycles), 64'h0);
    end else begin
      if (prev_idle && cmd_valid) build_trace(cmd_mask);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        prev_idle = 1'b0;
        chk("valid", 64'(slot_qreq_valid), 64'(e.v));
        chk("isreq", 64'(slot_qreq_isRequest), 64'(e.r));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("ready", 64'(cmd_ready), 64'h0);
        chk("done_valid", 64'(done_valid), 64'(e.dv));
        for (int s = 0; s < NS; s++)
          chk("data", slot_qreq_data[64*s +: 64], e.v[s] ? 64'h1 : 64'h0);
        if (e.dv) begin
          chk("done_q", 64'(done_quiesced), 64'(e.q));
          chk("done_t", 64'(done_timedout), 64'(e.t));
          chk("done_c", 64'(done_cycles), 64'(e.c));
          m_q = e.q; m_t = e.t; m_c = e.c;
        end
      end else begin
        prev_idle = 1'b1;
        chk("idle_valid", 64'(slot_qreq_valid), 64'h0);
        chk("idle_isreq", 64'(slot_qreq_isRequest), 64'h0);
        chk("idle_data", {63'b0, |slot_qreq_data}, 64'h0);
        chk("idle_ready", 64'(cmd_ready), 64'h1);
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_done_valid", 64'(done_valid), 64'h0);
        chk("idle_done_q", 64'(done_quiesced), 64'(m_q));
        chk("idle_done_t", 64'(done_timedout), 64'(m_t));
        chk("idle_done_c", 64'(done_cycles), 64'(m_c));
      end
    end
  end

  // Slot responders: answer on the scheduled poll cycle, otherwise noise.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (slot_qreq_isRequest[i]) poll_cnt[i] = 0;
      if (slot_qreq_valid[i] && !slot_qreq_isRequest[i]) begin
        poll_cnt[i]++;
        if (poll_cnt[i] == hit_at[i]) begin
          resp_v[i] = 1'b1;
          resp_d[64*i +: 64] = {$urandom, $urandom} | 64'h1;
        end else if ($urandom_range(0, 1) == 1) begin
          resp_v[i] = 1'b1;
          resp_d[64*i +: 64] = {$urandom, $urandom} & ~64'h1;
        end else begin
          resp_v[i] = 1'b0;
          resp_d[64*i +: 64] = {$urandom, $urandom};
        end
      end else begin
        resp_v[i] = 1'($urandom_range(0, 1));
        resp_d[64*i +: 64] = {$urandom, $urandom};
      end
    end
  end

  task automatic send_cmd(input logic [NS-1:0] m, output int acc);
    int b;
    b = 0;
    @(negedge clk);
    while (!cmd_ready && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_cmd: cmd_ready got 0 expected 1 within budget");
    end
    cmd_valid = 1'b1;
    cmd_mask  = m;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc_n - 1;
  endtask

  task automatic wait_done(output int dc);
    int b;
    b = 0;
    while (!done_valid && b < 3000) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (!done_valid) begin
      errors++;
      $display("FAIL wait_done: done_valid got 0 expected 1 within budget");
    end
    dc = cyc_n;
  endtask

  task automatic clear_hits();
    for (int i = 0; i < NS; i++) hit_at[i] = 0;
  endtask

  initial begin
    int a, d;
    clear_hits();
    for (int i = 0; i < NS; i++) poll_cnt[i] = 0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    // Single slot, immediate answer.
    hit_at[0] = 1;
    send_cmd(8'h01, a); wait_done(d);
    chk("t1_latency", 64'(d - a), 64'd4);
    chk("t1_quiesced", 64'(done_quiesced), 64'h01);
    chk("t1_timedout", 64'(done_timedout), 64'h00);
    chk("t1_cycles", 64'(done_cycles), 64'd3);

    // Three slots, each answers on its 5th poll.
    clear_hits(); hit_at[2] = 5; hit_at[5] = 5; hit_at[7] = 5;
    send_cmd(8'hA4, a); wait_done(d);
    chk("t2_quiesced", 64'(done_quiesced), 64'hA4);
    chk("t2_timedout", 64'(done_timedout), 64'h00);
    chk("t2_cycles", 64'(done_cycles), 64'd21);

    // Hung slot runs the full timeout.
    clear_hits();
    send_cmd(8'h08, a); wait_done(d);
    chk("t3_quiesced", 64'(done_quiesced), 64'h00);
    chk("t3_timedout", 64'(done_timedout), 64'h08);
    chk("t3_cycles", 64'(done_cycles), 64'd18);

    // Answer on the final timeout cycle counts as quiesced.
    clear_hits(); hit_at[3] = T;
    send_cmd(8'h08, a); wait_done(d);
    chk("t4_quiesced", 64'(done_quiesced), 64'h08);
    chk("t4_timedout", 64'(done_timedout), 64'h00);

    // Mixed: slot0 hung, slot3 answers at once.
    clear_hits(); hit_at[3] = 1;
    send_cmd(8'h09, a); wait_done(d);
    chk("t5_quiesced", 64'(done_quiesced), 64'h08);
    chk("t5_timedout", 64'(done_timedout), 64'h01);
    chk("t5_cycles", 64'(done_cycles), 64'd21);

    // Empty mask goes straight to DONE.
    send_cmd(8'h00, a); wait_done(d);
    chk("t6_latency", 64'(d - a), 64'd1);
    chk("t6_quiesced", 64'(done_quiesced), 64'h00);
    chk("t6_cycles", 64'(done_cycles), 64'd0);

    // cmd_valid held through a sweep; the new mask is taken only from IDLE.
    for (int i = 0; i < NS; i++) hit_at[i] = $urandom_range(0, T + 4);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mask = 8'h22;
    @(negedge clk);
    cmd_mask = 8'h41;
    wait_done(d);
    @(negedge clk);
    wait_done(d);
    cmd_valid = 1'b0;
    chk("t7_second_mask", 64'(done_quiesced | done_timedout), 64'h41);

    // Random sweeps.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NS; i++) hit_at[i] = $urandom_range(0, T + 4);
      send_cmd(NS'($urandom_range(0, 255)), a);
      wait_done(d);
    end

    // Reset in the middle of polling.
    clear_hits();
    send_cmd(8'h10, a);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t9_ready_after_release", 64'(cmd_ready), 64'h1);
    chk("t9_done_q_after_reset", 64'(done_quiesced), 64'h0);

    for (int i = 0; i < NS; i++) hit_at[i] = $urandom_range(0, T + 4);
    send_cmd(8'hFF, a); wait_done(d);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
